// File: rtl/picoctrl_prog_mem.sv
`default_nettype none
// ============================================================================
// Module : picoctrl_prog_mem
// Loadable PicoCtrl program RAM: valid/ready load stream, 1-cycle fetch port.
// Rev    : 1.0 - initial release
// ============================================================================
module picoctrl_prog_mem #(
  parameter int                 ADDR_W   = 5,
  parameter int                 INSTR_W  = 16,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] fetch_data,
  output logic               fetch_valid,
  input  logic               load_start,
  input  logic [ADDR_W-1:0]  load_base,
  input  logic [ADDR_W:0]    load_len,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_valid,
  output logic               load_ready,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_err,
  output logic               prog_ok,
  output logic [INSTR_W-1:0] checksum
);

  localparam int         c_DEPTH  = 1 << ADDR_W;
  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_LOAD = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [INSTR_W-1:0] r_mem [c_DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W:0]    r_remaining;
  logic [INSTR_W-1:0] r_checksum;
  logic [INSTR_W-1:0] r_fetch_data;
  logic               r_fetch_valid;
  logic               r_load_done;
  logic               r_load_err;
  logic               r_prog_ok;

  logic w_load_ready;
  logic w_load_busy;
  logic w_len_ok;
  logic w_start_ok;
  logic w_start_err;
  logic w_accept;
  logic w_last;

  // Legal length is 1..DEPTH: nonzero, and the top bit only set for exactly DEPTH.
  assign w_len_ok    = (load_len != '0) &&
                       (!load_len[ADDR_W] || (load_len[ADDR_W-1:0] == '0));
  assign w_start_ok  = load_start && (r_state == c_S_IDLE) && w_len_ok;
  assign w_start_err = load_start && ((r_state == c_S_LOAD) || !w_len_ok);
  assign w_accept    = load_valid && w_load_ready;
  assign w_last      = w_accept && (r_remaining == {{ADDR_W{1'b0}}, 1'b1});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (w_start_ok) w_state_nxt = c_S_LOAD;
      c_S_LOAD: if (w_last)     w_state_nxt = c_S_IDLE;
      default:                  w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_load_ready = 1'b0;
    w_load_busy  = 1'b0;
    if (r_state == c_S_LOAD) begin
      w_load_ready = 1'b1;
      w_load_busy  = 1'b1;
    end
  end

  // RAM has no reset; prog_ok masks stale contents on fetch.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_remaining   <= '0;
      r_checksum    <= '0;
      r_prog_ok     <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= NOP_WORD;
    end else begin
      r_load_done <= w_last;
      r_load_err  <= w_start_err;
      if (w_start_ok) begin
        r_wr_ptr    <= load_base;
        r_remaining <= load_len;
        r_checksum  <= '0;
        r_prog_ok   <= 1'b0;
      end else if (w_accept) begin
        r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
        r_remaining <= r_remaining - {{ADDR_W{1'b0}}, 1'b1};
        r_checksum  <= r_checksum + load_data;
        if (w_last) begin
          r_prog_ok <= 1'b1;
        end
      end
      if (fetch_en && (r_state == c_S_IDLE)) begin
        r_fetch_valid <= 1'b1;
        r_fetch_data  <= r_prog_ok ? r_mem[fetch_addr] : NOP_WORD;
      end else begin
        r_fetch_valid <= 1'b0;
      end
    end
  end

  assign fetch_data  = r_fetch_data;
  assign fetch_valid = r_fetch_valid;
  assign load_ready  = w_load_ready;
  assign load_busy   = w_load_busy;
  assign load_done   = r_load_done;
  assign load_err    = r_load_err;
  assign prog_ok     = r_prog_ok;
  assign checksum    = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_picoctrl_prog_mem.sv
`default_nettype none
// ============================================================================
// Module : tb_picoctrl_prog_mem
// Self-checking bench for picoctrl_prog_mem against a cycle-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_picoctrl_prog_mem;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               fetch_en;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [INSTR_W-1:0] fetch_data;
  logic               fetch_valid;
  logic               load_start;
  logic [ADDR_W-1:0]  load_base;
  logic [ADDR_W:0]    load_len;
  logic [INSTR_W-1:0] load_data;
  logic               load_valid;
  logic               load_ready;
  logic               load_busy;
  logic               load_done;
  logic               load_err;
  logic               prog_ok;
  logic [INSTR_W-1:0] checksum;

  always #5 clk = ~clk;

  picoctrl_prog_mem #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .NOP_WORD(16'h0000)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .prog_ok    (prog_ok),
    .checksum   (checksum)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain program-memory behaviour, one step per clock edge.
  logic [15:0] m_mem [DEPTH];
  bit          m_loading;
  int          m_ptr;
  int          m_rem;
  int          m_sum;
  bit          m_prog_ok;
  bit          m_done;
  bit          m_err;
  bit          m_fvalid;
  logic [15:0] m_fdata;

  logic [15:0] q_words[$];

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_ptr = 0; m_rem = 0; m_sum = 0; m_prog_ok = 0;
    m_done = 0; m_err = 0; m_fvalid = 0; m_fdata = 16'h0000;
  endtask

  task automatic idle_inputs();
    fetch_en = 0; fetch_addr = '0; load_start = 0; load_base = '0;
    load_len = '0; load_data = '0; load_valid = 0;
  endtask

  task automatic check_outputs();
    check_value("fetch_valid", fetch_valid, m_fvalid);
    check_value("fetch_data", fetch_data, m_fdata);
    check_value("load_ready", load_ready, m_loading);
    check_value("load_busy", load_busy, m_loading);
    check_value("load_done", load_done, m_done);
    check_value("load_err", load_err, m_err);
    check_value("prog_ok", prog_ok, m_prog_ok);
    check_value("checksum", checksum, m_sum[15:0]);
  endtask

  // Advance one clock: update the model from current inputs, then compare.
  task automatic cycle();
    bit bad_start;
    bad_start = load_start && (m_loading || load_len == 0 || int'(load_len) > DEPTH);
    if (fetch_en && !m_loading) begin
      m_fvalid = 1;
      m_fdata  = m_prog_ok ? m_mem[fetch_addr] : 16'h0000;
    end else begin
      m_fvalid = 0;
    end
    m_done = 0;
    if (m_loading) begin
      if (load_valid) begin
        m_mem[m_ptr] = load_data;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_sum = (m_sum + int'(load_data)) % 65536;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_loading = 0; m_done = 1; m_prog_ok = 1;
        end
      end
    end else if (load_start && !bad_start) begin
      m_loading = 1; m_ptr = int'(load_base); m_rem = int'(load_len);
      m_sum = 0; m_prog_ok = 0;
    end
    m_err = bad_start;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_fetch(input int addr);
    fetch_en = 1; fetch_addr = addr[ADDR_W-1:0];
    cycle();
    fetch_en = 0;
  endtask

  // Start a load of q_words; gaps on load_valid by gap_pct; optional
  // fetch/load_start injection during the load, optional abort after N words.
  task automatic run_load(input int base, input int gap_pct, input bit inject, input int abort_after);
    int idx;
    int guard;
    bit acc;
    load_start = 1; load_base = base[ADDR_W-1:0]; load_len = 6'(q_words.size());
    cycle();
    load_start = 0;
    idx = 0;
    guard = 0;
    while (idx < q_words.size() && guard < 1000) begin
      if (abort_after >= 0 && idx == abort_after) break;
      load_valid = ($urandom_range(99) >= gap_pct);
      load_data  = load_valid ? q_words[idx] : 16'($urandom);
      fetch_en   = inject;
      fetch_addr = 5'($urandom);
      load_start = inject && (idx == 2);
      load_len   = 6'd4;
      acc = load_valid && m_loading;
      cycle();
      if (inject) begin
        check_value("t5_fetch_in_load", fetch_valid, 1'b0);
        if (load_start) check_value("t5_err_in_load", load_err, 1'b1);
      end
      if (acc) idx++;
      guard++;
    end
    if (guard >= 1000) check_value("load_timeout", 0, 1);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 0;

    // 1: fetch with no program returns NOP
    do_fetch(5);
    check_value("t1_valid", fetch_valid, 1'b1);
    check_value("t1_nop", fetch_data, 16'h0000);
    check_value("t1_prog_ok", prog_ok, 1'b0);
    cycle();

    // 2: full 32-word load at base 0
    q_words.delete();
    for (int i = 0; i < 32; i++) q_words.push_back(16'h1000 + 16'(i));
    run_load(0, 0, 0, -1);
    check_value("t2_done", load_done, 1'b1);
    check_value("t2_prog_ok", prog_ok, 1'b1);
    check_value("t2_checksum", checksum, 16'h01F0);
    do_fetch(7);
    check_value("t2_fetch7", fetch_data, 16'h1007);

    // 3: wrapping load with gaps
    q_words.delete();
    q_words.push_back(16'hAAAA); q_words.push_back(16'hBBBB);
    q_words.push_back(16'hCCCC); q_words.push_back(16'hDDDD);
    run_load(30, 50, 0, -1);
    do_fetch(31);
    check_value("t3_fetch31", fetch_data, 16'hBBBB);
    do_fetch(0);
    check_value("t3_fetch0", fetch_data, 16'hCCCC);
    do_fetch(1);
    check_value("t3_fetch1", fetch_data, 16'hDDDD);
    do_fetch(2);
    check_value("t3_fetch2", fetch_data, 16'h1002);

    // 4: illegal lengths rejected
    for (int k = 0; k < 2; k++) begin
      load_start = 1; load_base = 5'd3; load_len = (k == 0) ? 6'd0 : 6'd33;
      cycle();
      load_start = 0;
      check_value("t4_err", load_err, 1'b1);
      check_value("t4_busy", load_busy, 1'b0);
      check_value("t4_prog_ok", prog_ok, 1'b1);
      cycle();
    end

    // 5: fetch and load_start during LOAD
    q_words.delete();
    for (int i = 0; i < 8; i++) q_words.push_back(16'($urandom));
    run_load(10, 30, 1, -1);
    check_value("t5_done", load_done, 1'b1);
    do_fetch(12);
    check_value("t5_fetch12", fetch_data, q_words[2]);

    // 6: async reset mid-load
    q_words.delete();
    for (int i = 0; i < 8; i++) q_words.push_back(16'($urandom));
    run_load(20, 0, 0, 3);
    #2;
    reset = 1;
    #1;
    check_value("t6_fvalid", fetch_valid, 1'b0);
    check_value("t6_fdata", fetch_data, 16'h0000);
    check_value("t6_busy", load_busy, 1'b0);
    check_value("t6_ready", load_ready, 1'b0);
    check_value("t6_prog_ok", prog_ok, 1'b0);
    check_value("t6_checksum", checksum, 16'h0000);
    model_reset();
    @(negedge clk);
    reset = 0;
    do_fetch(0);
    check_value("t6_fetch0", fetch_data, 16'h0000);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      fetch_en   = $urandom_range(1);
      fetch_addr = 5'($urandom);
      load_start = ($urandom_range(99) < 4);
      load_base  = 5'($urandom);
      load_len   = ($urandom_range(9) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(1, 12));
      load_valid = ($urandom_range(99) < 65);
      load_data  = 16'($urandom);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/picoctrl_prog_mem.md
Name: picoctrl_prog_mem

Overview:
Loadable, parametrised program memory for the PicoCtrl sequencer. It replaces the fixed 32-entry instruction table with a RAM that is written at run time through a valid/ready load stream. The PicoCtrl core fetches from it over a registered read port with 1-cycle latency. The block sits between the host/loader (UART or switch-driven) and the PicoCtrl core.

Parameters:
ADDR_W, 5, instruction address width; DEPTH = 2**ADDR_W.
INSTR_W, 16, instruction word width.
NOP_WORD, 16'h0000, word returned on fetch while no valid program is present (width INSTR_W).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
fetch_en  in  1  fetch request from core
fetch_addr  in  ADDR_W  instruction address
fetch_data  out  INSTR_W  fetched instruction, registered
fetch_valid  out  1  fetch_data valid this cycle
load_start  in  1  single-cycle pulse, begin program load
load_base  in  ADDR_W  first write address, sampled on load_start
load_len  in  ADDR_W+1  words to load, sampled on load_start; legal range 1..DEPTH
load_data  in  INSTR_W  load word
load_valid  in  1  load_data present
load_ready  out  1  block accepts load_data
load_busy  out  1  load in progress
load_done  out  1  1-cycle pulse after last word written
load_err  out  1  1-cycle pulse on rejected load_start
prog_ok  out  1  a complete program has been loaded since reset
checksum  out  INSTR_W  mod-2^INSTR_W sum of words accepted in current/last load

Behaviour:
- Reset (async, immediate): FSM=IDLE; fetch_data=NOP_WORD; fetch_valid=0; load_ready=0; load_busy=0; load_done=0; load_err=0; prog_ok=0; checksum=0; wr_ptr=0; remaining=0. RAM contents are not reset; prog_ok=0 masks them.
- FSM states: IDLE, LOAD.
- IDLE + load_start:
  - load_len==0 or load_len>DEPTH: load_err=1 for one cycle, stay IDLE, prog_ok unchanged.
  - Otherwise: wr_ptr<=load_base, remaining<=load_len, checksum<=0, prog_ok<=0, go to LOAD.
- LOAD: load_ready=1, load_busy=1.
  - Each cycle with load_valid&&load_ready: mem[wr_ptr]<=load_data; wr_ptr<=wr_ptr+1, wrapping modulo DEPTH (e.g. 31 to 0 at ADDR_W=5); checksum<=checksum+load_data, truncated; remaining<=remaining-1.
  - When the accepted word is the last one (remaining==1): next cycle load_done=1, prog_ok=1, FSM to IDLE, load_ready=0.
  - load_valid low: hold state, no write; no timeout.
  - load_start while in LOAD: ignored, load_err pulses, load continues.
- Fetch, 1-cycle latency:
  - At a clock edge with fetch_en=1 and FSM=IDLE: fetch_valid<=1; fetch_data<=prog_ok ? mem[fetch_addr] : NOP_WORD.
  - Otherwise (fetch_en=0, or FSM=LOAD): fetch_valid<=0 and fetch_data holds its last value.
  - Fetch and write never occur in the same cycle. In the IDLE cycle that samples load_start, a fetch is still served (reads pre-load data).
- Back-to-back fetches give one result per cycle.
- A load_done edge coincident with fetch_en: the FSM is still LOAD at that edge, so no fetch is served. The first fetch is served on the next edge with prog_ok=1.
- A reset asserted mid-load aborts the load: prog_ok=0 and fetches return NOP_WORD until a full reload.

Test Plan:
1. Reset, then fetch_en=1, addr=5 -> next cycle fetch_valid=1, fetch_data=16'h0000; prog_ok=0.
2. load_start, base=0, len=32, words 16'h1000+i, valid every cycle -> load_ready high 32 cycles, load_done pulse after word 31, prog_ok=1, checksum=16'h01F0; fetch addr 7 -> 16'h1007 one cycle later.
3. load_start, base=30, len=4, words A,B,C,D with load_valid gapped -> written to 30,31,0,1 (wrap); fetch 31 -> B, fetch 0 -> C, addr 2 unchanged from test 2 (16'h1002).
4. load_start with len=0, then with len=33 -> load_err pulses each time, load_busy stays 0, prog_ok stays 1.
5. During LOAD: fetch_en=1 -> fetch_valid=0; load_start pulse -> load_err=1, load continues to completion.
6. Assert reset after 3 of 8 words -> all outputs at reset values immediately; fetch addr 0 -> 16'h0000.
